// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the core: stage bundles, memory-stage FSM states,
// load/store funct3 codes and access-size helpers.
package pipeline;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      BUS_WAIT,
      RESP
   } mem_state_e;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W
   } acc_size_e;

   typedef struct packed {
      logic [2:0]      funct3;
      logic            mm_re;
      logic            mm_we;
      logic [XLEN-1:0] mm_addr;
      logic [XLEN-1:0] data;
      logic [4:0]      rd_addr;
   } memory_signals;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic [4:0]      rd_addr;
   } writeback_signals;

   // Stores only know SB/SH/SW; the unsigned load codes fall into the word bucket for stores.
   function automatic acc_size_e access_size(input logic [2:0] funct3, input logic is_store);
      acc_size_e sz;
      sz = SZ_W;
      if (funct3 == F3_B || (!is_store && funct3 == F3_BU)) sz = SZ_B;
      else if (funct3 == F3_H || (!is_store && funct3 == F3_HU)) sz = SZ_H;
      return sz;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic is_store,
                                          input logic [1:0] lane);
      logic mis;
      case (access_size(funct3, is_store))
         SZ_B:    mis = 1'b0;
         SZ_H:    mis = lane[0];
         default: mis = (lane != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// Selects and extends the addressed byte/halfword of a bus read word.
module load_align
   import pipeline::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);

   logic [7:0]  b_sel;
   logic [15:0] h_sel;

   // Lane select followed by sign or zero extension.
   always_comb begin
      b_sel = rdata[{addr, 3'b000} +: 8];
      h_sel = addr[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    result = {{(XLEN-8){b_sel[7]}}, b_sel};
         F3_BU:   result = {{(XLEN-8){1'b0}}, b_sel};
         F3_H:    result = {{(XLEN-16){h_sel[15]}}, h_sel};
         F3_HU:   result = {{(XLEN-16){1'b0}}, h_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: runs loads/stores on a ready/ack data bus and registers the
// writeback bundle. Non-memory instructions pass through in one cycle.
// Optional feature macro: MM_MISALIGN_TRAP_EN (misaligned accesses are trapped
// instead of issued, and reported on misalign/misalign_addr).
//
// state    | meaning
// IDLE     | ready for a new instruction
// BUS_WAIT | request held on the bus until dbus_ack
// RESP     | writeback pulse for the completed access
module memory_stage
   import pipeline::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  memory_signals    in_sig,
   output logic             dbus_re,
   output logic             dbus_we,
   output logic [XLEN-1:0]  dbus_addr,
   output logic [XLEN-1:0]  dbus_wdata,
   output logic [3:0]       dbus_be,
   input  logic [XLEN-1:0]  dbus_rdata,
   input  logic             dbus_ack,
   output logic             wb_valid,
   output writeback_signals wb_sig
`ifdef MM_MISALIGN_TRAP_EN
   ,
   output logic             misalign,
   output logic [XLEN-1:0]  misalign_addr
`endif
);

   mem_state_e      state, state_nxt;
   memory_signals   req_q;
   logic            is_mem;
   logic            trap;
   logic [XLEN-1:0] load_data;

   assign in_ready = (state == IDLE);
   assign is_mem   = in_sig.mm_re || in_sig.mm_we;

`ifdef MM_MISALIGN_TRAP_EN
   assign trap = is_mem && is_misaligned(in_sig.funct3, in_sig.mm_we, in_sig.mm_addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   load_align u_load_align (
      .rdata  (dbus_rdata),
      .addr   (req_q.mm_addr[1:0]),
      .funct3 (req_q.funct3),
      .result (load_data)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state and bus request, driven straight from the latched bundle so it stays stable.
   always_comb begin
      state_nxt  = state;
      dbus_re    = 1'b0;
      dbus_we    = 1'b0;
      dbus_addr  = '0;
      dbus_wdata = '0;
      dbus_be    = 4'b0000;
      case (state)
         IDLE: begin
            if (in_valid && is_mem && !trap) state_nxt = BUS_WAIT;
         end
         BUS_WAIT: begin
            dbus_re   = req_q.mm_re && !req_q.mm_we;
            dbus_we   = req_q.mm_we;
            dbus_addr = {req_q.mm_addr[XLEN-1:2], 2'b00};
            if (req_q.mm_we) begin
               case (access_size(req_q.funct3, 1'b1))
                  SZ_B: begin
                     dbus_wdata = {4{req_q.data[7:0]}};
                     dbus_be    = 4'b0001 << req_q.mm_addr[1:0];
                  end
                  SZ_H: begin
                     dbus_wdata = {2{req_q.data[15:0]}};
                     dbus_be    = 4'b0011 << {req_q.mm_addr[1], 1'b0};
                  end
                  default: begin
                     dbus_wdata = req_q.data;
                     dbus_be    = 4'b1111;
                  end
               endcase
            end
            if (dbus_ack) state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch and writeback register; stores write back x0 with zero data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_q    <= '0;
         wb_valid <= 1'b0;
         wb_sig   <= '0;
      end else begin
         wb_valid <= 1'b0;
         if (state == IDLE && in_valid) begin
            if (!is_mem) begin
               wb_valid       <= 1'b1;
               wb_sig.data    <= in_sig.data;
               wb_sig.rd_addr <= in_sig.rd_addr;
            end else if (!trap) begin
               req_q <= in_sig;
            end
         end
         if (state == BUS_WAIT && dbus_ack) begin
            wb_valid       <= 1'b1;
            wb_sig.data    <= req_q.mm_we ? '0 : load_data;
            wb_sig.rd_addr <= req_q.mm_we ? 5'd0 : req_q.rd_addr;
         end
      end
   end

`ifdef MM_MISALIGN_TRAP_EN
   // One-cycle trap report for a misaligned access accepted in IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         misalign      <= 1'b0;
         misalign_addr <= '0;
      end else begin
         misalign <= 1'b0;
         if (state == IDLE && in_valid && trap) begin
            misalign      <= 1'b1;
            misalign_addr <= in_sig.mm_addr;
         end
      end
   end
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: a cycle-indexed scoreboard of expected
// writebacks, bus requests and busy cycles, filled from the load/store rules.
// Honours MM_MISALIGN_TRAP_EN when the design is built with it.
module tb_memory_stage;
   import pipeline::*;

   typedef struct packed {
      logic        re;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_t;

   logic             clk;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   memory_signals    in_sig;
   logic             dbus_re, dbus_we;
   logic [31:0]      dbus_addr, dbus_wdata, dbus_rdata;
   logic [3:0]       dbus_be;
   logic             dbus_ack;
   logic             wb_valid;
   writeback_signals wb_sig;
`ifdef MM_MISALIGN_TRAP_EN
   logic             misalign;
   logic [31:0]      misalign_addr;
   localparam bit    MIS_EN = 1'b1;
`else
   localparam bit    MIS_EN = 1'b0;
`endif

   memory_stage dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_sig(in_sig),
      .dbus_re(dbus_re), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
      .dbus_be(dbus_be), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
      .wb_valid(wb_valid), .wb_sig(wb_sig)
`ifdef MM_MISALIGN_TRAP_EN
      , .misalign(misalign), .misalign_addr(misalign_addr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int  n_cmp = 0;
   int  n_bad = 0;
   bit  chk_en = 1'b0;

   writeback_signals exp_wb   [int];
   req_t             exp_req  [int];
   bit               exp_busy [int];
   logic [31:0]      exp_mis  [int];
   req_t             pin_req  [int];
   logic [31:0]      pin_wb   [int];

   bit          pin_req_on = 1'b0;
   req_t        pin_req_val;
   bit          pin_wb_on  = 1'b0;
   logic [31:0] pin_wb_val;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference rules ----------------
   function automatic int m_size(input logic [2:0] f3, input bit st);
      if (f3 == 3'b000) return 1;
      if (f3 == 3'b001) return 2;
      if (!st && f3 == 3'b100) return 1;
      if (!st && f3 == 3'b101) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] lane,
                                          input logic [2:0] f3);
      logic [31:0] v;
      int sz;
      sz = m_size(f3, 1'b0);
      if (sz == 4) return rd;
      if (sz == 1) v = (rd >> (8 * lane)) & 32'hFF;
      else         v = (rd >> (16 * lane[1])) & 32'hFFFF;
      if (f3[2] == 1'b0) begin
         if (sz == 1 && v >= 128)   v = v - 256;
         if (sz == 2 && v >= 32768) v = v - 65536;
      end
      return v;
   endfunction

   function automatic logic [3:0] m_be(input int sz, input logic [1:0] lane);
      if (sz == 1) return 4'(1 << lane);
      if (sz == 2) return 4'(3 << (lane & 2'b10));
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
      if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
      if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic bit m_mis(input int sz, input logic [1:0] lane);
      return (sz == 2 && lane[0]) || (sz == 4 && lane != 2'b00);
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         req_t r;
         bit   e_wb;
         chk("in_ready", 32'(in_ready), 32'(!exp_busy.exists(cyc)));
         e_wb = exp_wb.exists(cyc);
         chk("wb_valid", 32'(wb_valid), 32'(e_wb));
         if (e_wb && wb_valid) begin
            chk("wb_data", wb_sig.data, exp_wb[cyc].data);
            chk("wb_rd", 32'(wb_sig.rd_addr), 32'(exp_wb[cyc].rd_addr));
         end
         r = exp_req.exists(cyc) ? exp_req[cyc] : '0;
         chk("dbus_re", 32'(dbus_re), 32'(r.re));
         chk("dbus_we", 32'(dbus_we), 32'(r.we));
         chk("dbus_addr", dbus_addr, r.addr);
         chk("dbus_wdata", dbus_wdata, r.wdata);
         chk("dbus_be", 32'(dbus_be), 32'(r.be));
         if (pin_req.exists(cyc)) begin
            chk("lit_re", 32'(dbus_re), 32'(pin_req[cyc].re));
            chk("lit_we", 32'(dbus_we), 32'(pin_req[cyc].we));
            chk("lit_addr", dbus_addr, pin_req[cyc].addr);
            chk("lit_wdata", dbus_wdata, pin_req[cyc].wdata);
            chk("lit_be", 32'(dbus_be), 32'(pin_req[cyc].be));
         end
         if (pin_wb.exists(cyc)) chk("lit_wb_data", wb_sig.data, pin_wb[cyc]);
`ifdef MM_MISALIGN_TRAP_EN
         chk("misalign", 32'(misalign), 32'(exp_mis.exists(cyc)));
         if (exp_mis.exists(cyc)) chk("misalign_addr", misalign_addr, exp_mis[cyc]);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b0;
         dbus_ack = ($urandom % 2) == 1;
         dbus_rdata = $urandom;
         next_cycle();
      end
      dbus_ack = 1'b0;
   endtask

   // Issue one instruction in the current cycle, record what must follow, and
   // return in the first cycle a new instruction may be offered.
   task automatic do_instr(input memory_signals s, input int d, input logic [31:0] rdata);
      int c, sz;
      bit st;
      req_t r;
      writeback_signals w;
      c  = cyc;
      st = s.mm_we;
      sz = m_size(s.funct3, st);
      in_valid   = 1'b1;
      in_sig     = s;
      dbus_ack   = ($urandom % 2) == 1;
      dbus_rdata = $urandom;
      if (!(s.mm_re || s.mm_we)) begin
         exp_wb[c+1] = '{data: s.data, rd_addr: s.rd_addr};
         if (pin_wb_on) pin_wb[c+1] = pin_wb_val;
         pin_wb_on = 1'b0;
         next_cycle();
         in_valid = 1'b0;
         dbus_ack = 1'b0;
         return;
      end
      if (MIS_EN && m_mis(sz, s.mm_addr[1:0])) begin
         exp_mis[c+1] = s.mm_addr;
         pin_req_on = 1'b0;
         pin_wb_on  = 1'b0;
         next_cycle();
         in_valid = 1'b0;
         dbus_ack = 1'b0;
         return;
      end
      r.re    = !st;
      r.we    = st;
      r.addr  = s.mm_addr & ~32'h3;
      r.be    = st ? m_be(sz, s.mm_addr[1:0]) : 4'h0;
      r.wdata = st ? m_wdata(sz, s.data) : 32'h0;
      for (int i = 0; i <= d; i++) begin
         exp_req[c+1+i]  = r;
         exp_busy[c+1+i] = 1'b1;
      end
      exp_busy[c+2+d] = 1'b1;
      w.data    = st ? 32'h0 : m_load(rdata, s.mm_addr[1:0], s.funct3);
      w.rd_addr = st ? 5'd0 : s.rd_addr;
      exp_wb[c+2+d] = w;
      if (pin_req_on) pin_req[c+1] = pin_req_val;
      if (pin_wb_on)  pin_wb[c+2+d] = pin_wb_val;
      pin_req_on = 1'b0;
      pin_wb_on  = 1'b0;
      next_cycle();
      for (int i = 0; i <= d; i++) begin
         in_valid   = ($urandom % 2) == 1;
         dbus_ack   = (i == d);
         dbus_rdata = (i == d) ? rdata : $urandom;
         next_cycle();
      end
      in_valid   = ($urandom % 2) == 1;
      dbus_ack   = ($urandom % 2) == 1;
      dbus_rdata = $urandom;
      next_cycle();
      in_valid = 1'b0;
      dbus_ack = 1'b0;
   endtask

   function automatic memory_signals mk(input logic [2:0] f3, input bit re, input bit we,
                                        input logic [31:0] addr, input logic [31:0] data,
                                        input logic [4:0] rd);
      memory_signals s;
      s.funct3 = f3; s.mm_re = re; s.mm_we = we;
      s.mm_addr = addr; s.data = data; s.rd_addr = rd;
      return s;
   endfunction

   function automatic memory_signals rand_instr(input int kind);
      return mk(3'($urandom), kind[0], kind[1], $urandom, $urandom, 5'($urandom));
   endfunction

   initial begin
      #500us;
      $display("FAIL timeout: simulation did not finish, got no end, expected $finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_sig = '0; dbus_ack = 1'b0; dbus_rdata = '0;
      repeat (3) @(posedge clk);
      #3;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_sig", wb_sig.data | 32'(wb_sig.rd_addr), 32'd0);
      chk("rst_dbus_re", 32'(dbus_re), 32'd0);
      chk("rst_dbus_we", 32'(dbus_we), 32'd0);
      chk("rst_dbus_addr", dbus_addr, 32'd0);
      chk("rst_dbus_wdata", dbus_wdata, 32'd0);
      chk("rst_dbus_be", 32'(dbus_be), 32'd0);
`ifdef MM_MISALIGN_TRAP_EN
      chk("rst_misalign", 32'(misalign), 32'd0);
`endif
      reset_n = 1'b1;
      next_cycle();
      chk_en = 1'b1;

      // ALU pass-through followed by three more back to back.
      pin_wb_on = 1'b1; pin_wb_val = 32'h1234_5678;
      do_instr(mk(3'b000, 0, 0, 32'h0, 32'h1234_5678, 5'd5), 0, 32'h0);
      for (int i = 0; i < 3; i++) do_instr(rand_instr(0), 0, 32'h0);
      idle(2);

      // LB / LBU at 0x103.
      pin_req_on = 1'b1; pin_req_val = '{re: 1'b1, we: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'h0};
      pin_wb_on  = 1'b1; pin_wb_val = 32'hFFFF_FF80;
      do_instr(mk(3'b000, 1, 0, 32'h103, 32'h0, 5'd7), 0, 32'h80AA_BBCC);
      pin_wb_on  = 1'b1; pin_wb_val = 32'h0000_0080;
      do_instr(mk(3'b100, 1, 0, 32'h103, 32'h0, 5'd7), 0, 32'h80AA_BBCC);

      // SH at 0x202.
      pin_req_on = 1'b1;
      pin_req_val = '{re: 1'b0, we: 1'b1, addr: 32'h200, wdata: 32'hBEEF_BEEF, be: 4'b1100};
      pin_wb_on  = 1'b1; pin_wb_val = 32'h0;
      do_instr(mk(3'b001, 0, 1, 32'h202, 32'hDEAD_BEEF, 5'd9), 1, $urandom);

      // Slow ack, then ack in the first request cycle.
      do_instr(mk(3'b010, 1, 0, 32'h40, 32'h0, 5'd3), 5, 32'hCAFE_F00D);
      do_instr(mk(3'b010, 1, 0, 32'h44, 32'h0, 5'd4), 0, 32'h0BAD_1DEA);
      idle(1);

      // Misaligned word load (trapped only when the feature is built in).
      do_instr(mk(3'b010, 1, 0, 32'h301, 32'h0, 5'd6), 1, 32'h1111_2222);
      idle(2);

      // Reset while a request is on the bus; a late ack must not complete it.
      chk_en = 1'b0;
      in_valid = 1'b1;
      in_sig = mk(3'b010, 1, 0, 32'h400, 32'h0, 5'd8);
      next_cycle();
      in_valid = 1'b0;
      chk("midrst_req_on", 32'(dbus_re), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_re", 32'(dbus_re), 32'd0);
      chk("midrst_we", 32'(dbus_we), 32'd0);
      chk("midrst_addr", dbus_addr, 32'd0);
      chk("midrst_be", 32'(dbus_be), 32'd0);
      chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      next_cycle();
      dbus_ack = 1'b1; dbus_rdata = $urandom;
      next_cycle();
      dbus_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
         chk("late_ack_re", 32'(dbus_re), 32'd0);
         chk("late_ack_in_ready", 32'(in_ready), 32'd1);
      end
      next_cycle();
      chk_en = 1'b1;

      // Randomised mix.
      for (int i = 0; i < 400; i++) begin
         do_instr(rand_instr($urandom % 4), $urandom % 4, $urandom);
         if ($urandom % 5 == 0) idle(1 + $urandom % 2);
      end
      idle(3);
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth pipeline stage of the core: consumes the `memory_signals` bundle from execute, runs loads and stores on the data bus with a ready/ack handshake, and produces a registered `writeback_signals` bundle for the writeback stage. Non-memory instructions pass through with one cycle of latency. Memory instructions stall the upstream stage until the bus acknowledges.

## Interface
Parameters
- `XLEN`, 32, datapath width, taken from the `pipeline` package.

Ports
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_sig` holds a valid instruction.
- `in_ready`  out  1  stage can accept; equals `state == IDLE`.
- `in_sig`  in  `memory_signals`  funct3, mm_re, mm_we, mm_addr, data (store data or ALU result), rd_addr.
- `dbus_re`  out  1  read request.
- `dbus_we`  out  1  write request.
- `dbus_addr`  out  32  word address; bits [1:0] are always 0.
- `dbus_wdata`  out  32  lane-replicated store data.
- `dbus_be`  out  4  byte enables; 0 on reads.
- `dbus_rdata`  in  32  read data; valid when `dbus_ack` is high.
- `dbus_ack`  in  1  completes the outstanding request.
- `wb_valid`  out  1  `wb_sig` is valid this cycle. There is no backpressure.
- `wb_sig`  out  `writeback_signals`  data and rd_addr.
- `misalign`  out  1  misaligned-access pulse. Exists only with `MM_MISALIGN_TRAP_EN`.
- `misalign_addr`  out  32  faulting address. Exists only with `MM_MISALIGN_TRAP_EN`.

## Operation
- FSM states:
  - `IDLE`: ready for a new instruction.
  - `BUS_WAIT`: request held on the bus.
  - `RESP`: writeback emitted.
- Instruction acceptance (`in_valid & in_ready`):
  - mm_re=0 and mm_we=0: latch data and rd_addr into the wb register. Assert `wb_valid` next cycle. Stay in `IDLE`.
  - Otherwise: latch the whole bundle and go to `BUS_WAIT`.
  - mm_we takes precedence if both mm_re and mm_we are set.
- `BUS_WAIT`:
  - Drive `dbus_re` or `dbus_we` with address, wdata and be from the latched bundle.
  - Hold all of them stable until `dbus_ack`.
  - On ack, capture aligned and extended read data, then go to `RESP`.
- `RESP`: assert `wb_valid` for one cycle, then go to `IDLE`.
- Load alignment, using lane = addr[1:0]:
  - funct3 000 LB: sign-extend the selected byte.
  - 100 LBU: zero-extend the selected byte.
  - 001 LH: sign-extend the halfword selected by addr[1].
  - 101 LHU: zero-extend that halfword.
  - 010 and all other codes: LW.
- Store encoding:
  - SB: byte replicated across all 4 lanes; be = 1 << addr[1:0].
  - SH: halfword replicated; be = 4'b0011 << (2*addr[1]).
  - SW, and any other code: be = 4'b1111.
- A store writes back rd_addr = 0 (no register write) and data = 0.
- A `dbus_ack` arriving outside `BUS_WAIT` is ignored.
- `in_valid` is ignored while `in_ready` is 0. Upstream holds `in_sig`.

## Timing
- Reset values: `state=IDLE`, `wb_valid=0`, `wb_sig=0`, all `dbus_*` outputs 0, `misalign=0`.
- Reset mid-transaction drops the request immediately (asynchronous) and discards it.
- Non-memory instruction: accepted at cycle 0, `wb_valid` at cycle 1. Back-to-back issue gives one writeback per cycle.
- Memory instruction:
  - Accepted at cycle 0.
  - Request visible from cycle 1.
  - Ack at cycle k ≥ 1, which may arrive in the first request cycle.
  - `wb_valid` at k+1.
  - `in_ready` is high again at k+2.
  - Minimum load-to-load spacing is 3 cycles.
- `wb_valid` is a single-cycle pulse per instruction and is never high while `in_ready` is low, except in the `RESP` cycle.

## Configuration
- `MM_MISALIGN_TRAP_EN` defined:
  - Triggers on a halfword access with addr[0]=1, or a word access with addr[1:0]≠0.
  - The access never goes to the bus.
  - Accepting it pulses `misalign` and drives `misalign_addr` on the next cycle.
  - No `wb_valid` is produced and the state stays `IDLE`.
- Undefined:
  - `misalign` and `misalign_addr` ports are absent.
  - Halfword accesses use addr[1] only; word accesses ignore addr[1:0].

## Structure
- Add to the `pipeline` package:
  - `mem_state_e` enum (`IDLE`, `BUS_WAIT`, `RESP`).
  - Funct3 localparams: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
- Reuse the existing `memory_signals` and `writeback_signals` structs unchanged.
- One combinational sub-module, `load_align`: inputs rdata, addr[1:0], funct3; output is the extended XLEN result.

## Test plan
- ALU pass-through: data=0x1234_5678, rd=5 → next cycle `wb_valid=1`, data 0x1234_5678, rd 5. Check 4 back-to-back instructions with no bubbles.
- LB at addr 0x103 with rdata 0x80AA_BBCC → `dbus_addr=0x100`, wb data 0xFFFF_FF80. Repeat as LBU → 0x0000_0080.
- SH at addr 0x202, data 0xDEAD_BEEF → `dbus_we=1`, `be=4'b1100`, wdata 0xBEEF_BEEF, wb rd_addr 0.
- Load with ack delayed 5 cycles → request held stable, `in_ready=0` throughout, `wb_valid` exactly one cycle after ack. Then repeat with ack in the first request cycle.
- Assert `reset_n` low during `BUS_WAIT` → all outputs 0 immediately. A late ack after release produces no `wb_valid`.
- With `MM_MISALIGN_TRAP_EN`: LW at 0x301 → no bus request, `misalign=1`, `misalign_addr=0x301`, no writeback.
